// File: rtl/alu_step_sequencer.sv
`default_nettype none
// alu_step_sequencer: decodes one fetched instruction and issues one-hot ALU step strobes,
// replacing the free-running phase clocks; stalls on mem_busy. Revision 1.0
module alu_step_sequencer #(
  parameter int MAX_STALL = 255,
  parameter int STALL_W   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ope_valid,
  input  logic [31:0] ope,
  output logic        ope_ready,
  input  logic        mem_busy,
  output logic [31:0] ope_q,
  output logic [3:0]  num_of_ope,
  output logic [2:0]  step,
  output logic        busy,
  output logic        retire,
  output logic        illegal_op,
  output logic        stall_abort
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC1  = 3'd1,
    S_EXEC2  = 3'd2,
    S_EXEC3  = 3'd3,
    S_RETIRE = 3'd4
  } state_t;

  state_t             state_q;
  logic [1:0]         nsteps_q;
  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] stall_cnt_d;
  logic [2:0]         step_q;
  logic               busy_q;
  logic               retire_q;
  logic               illegal_q;
  logic               abort_q;

  logic               dec_legal;
  logic [1:0]         dec_steps;
  logic [3:0]         dec_len;
  logic               accept;
  logic [1:0]         exec_k;

  always_comb begin
    dec_legal = 1'b1;
    dec_steps = 2'd0;
    dec_len   = 4'd1;
    case (ope[31:24])
      8'h55, 8'h53, 8'h5d, 8'hc3: begin dec_steps = 2'd2; dec_len = 4'd1; end
      8'h89:                      begin dec_steps = 2'd1; dec_len = 4'd2; end
      8'hb8:                      begin dec_steps = 2'd1; dec_len = 4'd5; end
      8'he8:                      begin dec_steps = 2'd3; dec_len = 4'd5; end
      8'h6a:                      begin dec_steps = 2'd2; dec_len = 4'd2; end
      8'h8b:                      begin dec_steps = 2'd2; dec_len = 4'd3; end
      8'hc9:                      begin dec_steps = 2'd3; dec_len = 4'd1; end
      8'h75, 8'heb:               begin dec_steps = 2'd1; dec_len = 4'd2; end
      8'h83: begin
        case (ope[23:16])
          8'he8, 8'hc4, 8'hec: begin dec_steps = 2'd1; dec_len = 4'd3; end
          8'h7d:               begin dec_steps = 2'd2; dec_len = 4'd4; end
          default:             dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Reset gates ready so fetch never sees an accept while held in reset.
  assign ope_ready   = reset_n & ((state_q == S_IDLE) | (state_q == S_RETIRE));
  assign accept      = ope_valid & ope_ready;
  assign exec_k      = state_q[1:0];
  assign stall_cnt_d = stall_cnt_q + 1'b1;

  // The registered strobe is masked in the same cycle a stall holds the step.
  assign step        = step_q & {3{~mem_busy}};
  assign busy        = busy_q;
  assign retire      = retire_q;
  assign illegal_op  = illegal_q;
  assign stall_abort = abort_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ope_q       <= 32'd0;
      num_of_ope  <= 4'd0;
      nsteps_q    <= 2'd0;
      stall_cnt_q <= '0;
      step_q      <= 3'b000;
      busy_q      <= 1'b0;
      retire_q    <= 1'b0;
      illegal_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      abort_q   <= 1'b0;
      step_q    <= 3'b000;
      case (state_q)
        S_IDLE, S_RETIRE: begin
          if (accept) begin
            ope_q       <= ope;
            num_of_ope  <= dec_len;
            nsteps_q    <= dec_steps;
            stall_cnt_q <= '0;
            busy_q      <= 1'b1;
            if (dec_legal) begin
              state_q <= S_EXEC1;
              step_q  <= 3'b001;
            end else begin
              state_q   <= S_RETIRE;
              retire_q  <= 1'b1;
              illegal_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_EXEC1, S_EXEC2, S_EXEC3: begin
          if (mem_busy) begin
            if (stall_cnt_d == STALL_W'(MAX_STALL)) begin
              state_q     <= S_RETIRE;
              abort_q     <= 1'b1;
              stall_cnt_q <= '0;
            end else begin
              stall_cnt_q <= stall_cnt_d;
              step_q      <= step_q;
            end
          end else begin
            stall_cnt_q <= '0;
            if (exec_k == nsteps_q) begin
              state_q  <= S_RETIRE;
              retire_q <= 1'b1;
            end else begin
              state_q <= (state_q == S_EXEC1) ? S_EXEC2 : S_EXEC3;
              step_q  <= {step_q[1:0], 1'b0};
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_step_sequencer.sv
`default_nettype none
// tb_alu_step_sequencer: directed and randomized checks of alu_step_sequencer against a
// transaction-level reference model. Revision 1.0
module tb_alu_step_sequencer;

  localparam int MAXS = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ope_valid = 1'b0;
  logic [31:0] ope = 32'd0;
  logic        mem_busy = 1'b0;
  logic        ope_ready;
  logic [31:0] ope_q;
  logic [3:0]  num_of_ope;
  logic [2:0]  step;
  logic        busy;
  logic        retire;
  logic        illegal_op;
  logic        stall_abort;

  int checks = 0;
  int errors = 0;

  alu_step_sequencer #(.MAX_STALL(MAXS), .STALL_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .ope_valid(ope_valid), .ope(ope),
    .ope_ready(ope_ready), .mem_busy(mem_busy), .ope_q(ope_q),
    .num_of_ope(num_of_ope), .step(step), .busy(busy), .retire(retire),
    .illegal_op(illegal_op), .stall_abort(stall_abort)
  );

  always #5 clock = ~clock;

  // Reference model: an instruction is either absent, working through its step list,
  // or in its retire cycle.
  bit          m_known = 0;
  bit          m_inflight = 0;
  bit          m_retiring = 0;
  int          m_todo[$];
  int          m_stall = 0;
  bit          m_ret = 0, m_ill = 0, m_abort = 0;
  logic [31:0] m_ope = 0;
  int          m_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input logic [31:0] op, output int steps, output int len,
                                 output bit legal);
    byte unsigned ops[12]   = '{8'h55, 8'h53, 8'h5d, 8'hc3, 8'h89, 8'hb8,
                                8'he8, 8'h6a, 8'h8b, 8'hc9, 8'h75, 8'heb};
    int           nst[12]   = '{2, 2, 2, 2, 1, 1, 3, 2, 2, 3, 1, 1};
    int           lens[12]  = '{1, 1, 1, 1, 2, 5, 5, 2, 3, 1, 2, 2};
    steps = 0; len = 1; legal = 0;
    for (int i = 0; i < 12; i++)
      if (op[31:24] == ops[i]) begin steps = nst[i]; len = lens[i]; legal = 1; end
    if (op[31:24] == 8'h83) begin
      if (op[23:16] inside {8'he8, 8'hc4, 8'hec}) begin steps = 1; len = 3; legal = 1; end
      else if (op[23:16] == 8'h7d) begin steps = 2; len = 4; legal = 1; end
    end
  endfunction

  task automatic model_check();
    logic [31:0] e_step;
    bit          e_ready;
    e_ready = reset_n && (!m_inflight || m_retiring);
    if (!m_known) begin
      check("ready_in_reset", {31'd0, ope_ready}, 32'd0);
      return;
    end
    e_step = (m_inflight && !m_retiring && !mem_busy) ? (32'd1 << (m_todo[0] - 1)) : 32'd0;
    check("ope_ready", {31'd0, ope_ready}, {31'd0, e_ready});
    check("step", {29'd0, step}, e_step);
    check("busy", {31'd0, busy}, {31'd0, m_inflight});
    check("retire", {31'd0, retire}, {31'd0, m_ret});
    check("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
    check("stall_abort", {31'd0, stall_abort}, {31'd0, m_abort});
    check("ope_q", ope_q, m_ope);
    check("num_of_ope", {28'd0, num_of_ope}, m_len);
  endtask

  task automatic model_edge();
    int  st, ln;
    bit  lg;
    if (!reset_n) begin
      m_known = 1; m_inflight = 0; m_retiring = 0; m_todo = {};
      m_stall = 0; m_ret = 0; m_ill = 0; m_abort = 0; m_ope = 0; m_len = 0;
      return;
    end
    m_ret = 0; m_ill = 0; m_abort = 0;
    if (!m_inflight || m_retiring) begin
      if (ope_valid) begin
        decode(ope, st, ln, lg);
        m_ope = ope; m_len = ln; m_stall = 0; m_inflight = 1; m_todo = {};
        for (int s = 1; s <= st; s++) m_todo.push_back(s);
        m_retiring = !lg;
        m_ret = !lg; m_ill = !lg;
      end else begin
        m_inflight = 0; m_retiring = 0;
      end
    end else if (mem_busy) begin
      m_stall++;
      if (m_stall >= MAXS) begin
        m_stall = 0; m_todo = {}; m_retiring = 1; m_abort = 1;
      end
    end else begin
      m_stall = 0;
      void'(m_todo.pop_front());
      if (m_todo.size() == 0) begin m_retiring = 1; m_ret = 1; end
    end
  endtask

  task automatic cyc(input bit rn, input bit v, input logic [31:0] op, input bit mb);
    @(negedge clock);
    reset_n = rn; ope_valid = v; ope = op; mem_busy = mb;
    #1;
    model_check();
    model_edge();
  endtask

  function automatic logic [31:0] pick_op();
    logic [31:0] r;
    byte unsigned pool[16] = '{8'h55, 8'h53, 8'h5d, 8'hc3, 8'h89, 8'hb8, 8'he8, 8'h6a,
                               8'h8b, 8'hc9, 8'h75, 8'heb, 8'h83, 8'h83, 8'h00, 8'hff};
    byte unsigned mrm[5]   = '{8'he8, 8'hc4, 8'hec, 8'h7d, 8'h11};
    r = $urandom;
    r[31:24] = pool[$urandom_range(0, 15)];
    if (r[31:24] == 8'h83) r[23:16] = mrm[$urandom_range(0, 4)];
    if (r[31:24] == 8'h00) r[31:24] = 8'($urandom);
    return r;
  endfunction

  initial begin
    int burst;
    // Reset with a valid instruction offered
    repeat (3) cyc(0, 1, 32'he8eeffff, 0);
    check("reset_step", {29'd0, step}, 32'd0);
    check("reset_ope_q", ope_q, 32'd0);
    cyc(1, 0, 32'd0, 0);
    check("ready_after_reset", {31'd0, ope_ready}, 32'd1);

    // Three-step call
    cyc(1, 1, 32'he8eeffff, 0);
    cyc(1, 0, 32'd0, 0); check("call_s1", {29'd0, step}, 32'd1);
    cyc(1, 0, 32'd0, 0); check("call_s2", {29'd0, step}, 32'd2);
    cyc(1, 0, 32'd0, 0); check("call_s3", {29'd0, step}, 32'd4);
    check("call_ope_q", ope_q, 32'he8eeffff);
    cyc(1, 0, 32'd0, 0); check("call_retire", {31'd0, retire}, 32'd1);
    check("call_len", {28'd0, num_of_ope}, 32'd5);

    // Group 83 legal, then illegal ModR/M
    cyc(1, 1, 32'h837dfc05, 0);
    cyc(1, 0, 32'd0, 0);
    cyc(1, 0, 32'd0, 0); check("g83_s2", {29'd0, step}, 32'd2);
    check("g83_len", {28'd0, num_of_ope}, 32'd4);
    cyc(1, 0, 32'd0, 0);
    cyc(1, 1, 32'h83aa0000, 0);
    cyc(1, 0, 32'd0, 0);
    check("ill_retire", {30'd0, retire, illegal_op}, 32'd3);
    check("ill_step", {29'd0, step}, 32'd0);
    check("ill_len", {28'd0, num_of_ope}, 32'd1);

    // Stall below the limit, then at the limit
    cyc(1, 1, 32'h55000000, 0);
    repeat (3) cyc(1, 0, 32'd0, 1);
    cyc(1, 0, 32'd0, 0); check("stall_s1", {29'd0, step}, 32'd1);
    cyc(1, 0, 32'd0, 0); check("stall_s2", {29'd0, step}, 32'd2);
    cyc(1, 0, 32'd0, 0); check("stall_retire", {31'd0, retire}, 32'd1);
    cyc(1, 1, 32'h55000000, 0);
    repeat (MAXS) cyc(1, 0, 32'd0, 1);
    cyc(1, 0, 32'd0, 0);
    check("abort_pulse", {30'd0, stall_abort, retire}, 32'd2);
    cyc(1, 0, 32'd0, 0); check("abort_no_s2", {29'd0, step}, 32'd0);

    // Back-to-back issue
    cyc(1, 1, 32'h89d80000, 0);
    cyc(1, 1, 32'hb8010203, 0);
    cyc(1, 1, 32'hb8010203, 0);
    check("b2b_accept", {30'd0, retire, ope_ready}, 32'd3);
    cyc(1, 0, 32'd0, 0); check("b2b_s1", {29'd0, step}, 32'd1);
    check("b2b_ope_q", ope_q, 32'hb8010203);
    cyc(1, 0, 32'd0, 0);

    // Reset during EXEC2
    cyc(1, 1, 32'hc9000000, 0);
    cyc(1, 0, 32'd0, 0);
    cyc(0, 0, 32'd0, 0);
    cyc(1, 0, 32'd0, 0);
    check("midrst_quiet", {28'd0, step, retire}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);

    // Randomized traffic
    burst = 0;
    for (int n = 0; n < 600; n++) begin
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(2, 6);
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0), pick_op(),
          (burst > 0) || ($urandom_range(0, 5) == 0));
      if (burst > 0) burst--;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
